// File: rtl/alu_arbiter.sv
// Shares one external ALU among NUM_REQ requesters: IDLE grants and latches operands, EXEC
// captures the result, DONE retires. Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority).

module alu_arbiter_lane #(
  parameter int WIDTH = 12
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] a_m,
  output logic [WIDTH-1:0] b_m,
  output logic [2:0]       op_m
);
  // Gated contribution to the AND-OR operand mux; at most one lane is selected.
  assign a_m  = sel ? a  : '0;
  assign b_m  = sel ? b  : '0;
  assign op_m = sel ? op : '0;
endmodule

module alu_arbiter #(
  parameter int WIDTH   = 12,
  parameter int NUM_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]     req_op,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       done,
  output logic signed [WIDTH-1:0]  result,
  output logic                     err,
  output logic signed [WIDTH-1:0]  alu_a,
  output logic signed [WIDTH-1:0]  alu_b,
  output logic [2:0]               alu_op,
  input  logic signed [WIDTH-1:0]  alu_c
);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state, state_n;
  logic   grant;
  logic   [NUM_REQ-1:0] gnt, gnt_q;
  logic   [NUM_REQ-1:0][WIDTH-1:0] a_v, b_v, a_m, b_m;
  logic   [NUM_REQ-1:0][2:0] op_v, op_m;
  logic   [WIDTH-1:0] sel_a, sel_b;
  logic   [2:0] sel_op;
  logic   illegal;

  assign a_v  = req_a;
  assign b_v  = req_b;
  assign op_v = req_op;

  // ---------------- winner selection ----------------
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic [PW-1:0] ptr, win_idx, cand;
  int            idx;

  // First requester strictly after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    gnt     = '0;
    win_idx = '0;
    cand    = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PW'(idx);
      if (gnt == '0 && req[cand]) begin
        gnt[cand] = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        ptr <= PW'(NUM_REQ-1);
    else if (grant) ptr <= win_idx;
  end
`else
  always_comb begin
    gnt = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end
`endif

  // ---------------- operand mux ----------------
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    alu_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
      .sel  (gnt[i]),
      .a    (a_v[i]),
      .b    (b_v[i]),
      .op   (op_v[i]),
      .a_m  (a_m[i]),
      .b_m  (b_m[i]),
      .op_m (op_m[i])
    );
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a  = sel_a  | a_m[i];
      sel_b  = sel_b  | b_m[i];
      sel_op = sel_op | op_m[i];
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    case (state)
      IDLE: if (|req) begin
        grant   = 1'b1;
        state_n = EXEC;
      end
      EXEC:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign illegal = (alu_op == 3'd7);

  // ---------------- datapath / outputs ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ack    <= '0;
      done   <= '0;
      err    <= 1'b0;
      result <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      gnt_q  <= '0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          alu_a  <= sel_a;
          alu_b  <= sel_b;
          alu_op <= sel_op;
          ack    <= gnt;
          gnt_q  <= gnt;
        end
        EXEC: begin
          ack    <= '0;
          done   <= gnt_q;
          err    <= illegal;
          result <= illegal ? '0 : alu_c;
        end
        DONE: begin
          done <= '0;
          err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_alu_arbiter;
  localparam int W  = 12;
  localparam int NR = 4;

  logic clk, rst;
  logic [NR-1:0] req;
  logic [NR-1:0][W-1:0] ta, tbv;
  logic [NR-1:0][2:0] top;
  logic [NR-1:0] ack, done;
  logic signed [W-1:0] result, alu_a, alu_b, alu_c;
  logic err;
  logic [2:0] alu_op;

  int n_checks = 0;
  int n_fail   = 0;
  int rr_last  = NR-1;

  alu_arbiter #(.WIDTH(W), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(ta), .req_b(tbv), .req_op(top),
    .ack(ack), .done(done), .result(result), .err(err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: add, sub, and a few logical ops; op 7 returns a+b so forcing to 0 is visible.
  function automatic logic signed [W-1:0] alu_f(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                                input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      default: return a + b;
    endcase
  endfunction

  always_comb alu_c = alu_f(alu_a, alu_b, alu_op);

  // Arbitration rule from the requirements, independent of any hardware encoding.
  function automatic int pick(input logic [NR-1:0] r);
`ifdef ALU_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NR; k++) begin
      int i = (rr_last + k) % NR;
      if (r[i]) return i;
    end
`else
    for (int i = 0; i < NR; i++) if (r[i]) return i;
`endif
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input int a, input int b, input int op);
    ta[i]  = W'(a);
    tbv[i] = W'(b);
    top[i] = 3'(op);
    req[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
    rr_last = NR-1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    n_checks++;
    if ({ack, done, err, result, alu_a, alu_b, alu_op} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b done=%b err=%b result=%0d alu_a=%0d alu_b=%0d alu_op=%0d, expected all 0",
               ack, done, err, result, alu_a, alu_b, alu_op);
    end
    rst = 1'b0;
    rr_last = NR-1;
  endtask

  task automatic test_single();
    drive(0, 10, 3, 0);
    step();
    n_checks++;
    if (ack !== 4'b0001 || done !== 4'b0000) begin
      n_fail++; $display("FAIL single_ack: ack=%b done=%b, expected ack=0001 done=0000", ack, done);
    end
    n_checks++;
    if (alu_a !== 12'sd10 || alu_b !== 12'sd3 || alu_op !== 3'd0) begin
      n_fail++; $display("FAIL single_latch: a=%0d b=%0d op=%0d, expected 10 3 0", alu_a, alu_b, alu_op);
    end
    req = '0;
    step();
    n_checks++;
    if (ack !== 4'b0000 || done !== 4'b0001 || result !== 12'sd13 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: ack=%b done=%b result=%0d err=%b, expected 0000 0001 13 0", ack, done, result, err);
    end
    step();
    n_checks++;
    if (done !== 4'b0000 || err !== 1'b0) begin
      n_fail++; $display("FAIL single_retire: done=%b err=%b, expected 0000 0", done, err);
    end
    // Back in IDLE: a fresh request is granted at the very next edge.
    drive(0, 1, 1, 0);
    step();
    n_checks++;
    if (ack !== 4'b0001) begin
      n_fail++; $display("FAIL single_idle_regrant: ack=%b, expected 0001", ack);
    end
    req = '0;
    step();
    step();
  endtask

  task automatic test_signed();
    drive(2, 20, -30, 1);
    step();
    n_checks++;
    if (ack !== 4'b0100) begin
      n_fail++; $display("FAIL signed_ack: ack=%b, expected 0100", ack);
    end
    req = '0;
    step();
    n_checks++;
    if (done !== 4'b0100 || result !== 12'sd50 || err !== 1'b0) begin
      n_fail++; $display("FAIL signed_done: done=%b result=%0d err=%b, expected 0100 50 0", done, result, err);
    end
    step();
  endtask

  task automatic test_illegal();
    drive(0, 5, 6, 7);
    step();
    n_checks++;
    if (ack !== 4'b0001) begin
      n_fail++; $display("FAIL illegal_ack: ack=%b, expected 0001", ack);
    end
    req = '0;
    step();
    n_checks++;
    if (done !== 4'b0001 || result !== 12'sd0 || err !== 1'b1) begin
      n_fail++; $display("FAIL illegal_done: done=%b result=%0d err=%b, expected 0001 0 1", done, result, err);
    end
    step();
    n_checks++;
    if (done !== 4'b0000 || err !== 1'b0) begin
      n_fail++; $display("FAIL illegal_retire: done=%b err=%b, expected 0000 0", done, err);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
`ifdef ALU_ARB_ROUND_ROBIN_EN
    begin
      int nack = 0;
      int prev = 0;
      for (int i = 0; i < NR; i++) drive(i, i + 1, 2 * i, 0);
      for (int c = 1; c <= 30 && nack < NR; c++) begin
        step();
        if (ack !== '0) begin
          int idx = -1;
          for (int k = 0; k < NR; k++) if (ack[k]) idx = k;
          n_checks++;
          if (!$onehot(ack) || idx != nack) begin
            n_fail++; $display("FAIL rr_order: ack=%b (index %0d), expected index %0d", ack, idx, nack);
          end
          if (nack > 0) begin
            n_checks++;
            if (c - prev != 3) begin
              n_fail++; $display("FAIL rr_spacing: %0d cycles between acks, expected 3", c - prev);
            end
          end
          prev = c;
          nack++;
          req = req & ~ack;
        end
      end
      n_checks++;
      if (nack != NR) begin
        n_fail++; $display("FAIL rr_all_acked: %0d acks within budget, expected %0d", nack, NR);
      end
    end
`else
    begin
      int cnt1 = 0;
      int cnt3 = 0;
      drive(1, 4, 4, 0);
      drive(3, 9, 9, 1);
      for (int c = 1; c <= 15; c++) begin
        step();
        if (ack[1]) cnt1++;
        if (ack[3]) cnt3++;
      end
      n_checks++;
      if (cnt1 != 5) begin
        n_fail++; $display("FAIL fixed_req1_served: %0d acks, expected 5", cnt1);
      end
      n_checks++;
      if (cnt3 != 0) begin
        n_fail++; $display("FAIL fixed_req3_starved: %0d acks, expected 0", cnt3);
      end
    end
`endif
    req = '0;
    step();
    step();
    step();
  endtask

  task automatic test_reset_mid();
    drive(0, 7, 8, 0);
    step();
    n_checks++;
    if (ack !== 4'b0001) begin
      n_fail++; $display("FAIL midrst_ack: ack=%b, expected 0001", ack);
    end
    rst = 1'b1;
    req = '0;
    step();
    n_checks++;
    if ({ack, done, err, result, alu_a, alu_b, alu_op} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: ack=%b done=%b err=%b result=%0d alu_a=%0d alu_b=%0d alu_op=%0d, expected all 0",
               ack, done, err, result, alu_a, alu_b, alu_op);
    end
    rst = 1'b0;
    rr_last = NR-1;
    drive(3, 100, -1, 0);
    step();
    n_checks++;
    if (ack !== 4'b1000 || done !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_regrant: ack=%b done=%b, expected 1000 0000", ack, done);
    end
    req = '0;
    step();
    n_checks++;
    if (done !== 4'b1000 || result !== 12'sd99) begin
      n_fail++; $display("FAIL midrst_done: done=%b result=%0d, expected 1000 99", done, result);
    end
    step();
  endtask

  task automatic test_random();
    int busy = 0;
    int cur  = 0;
    logic signed [W-1:0] cur_res;
    logic cur_ill;
    logic [NR-1:0] exp_ack, exp_done;
    logic signed [W-1:0] exp_res;
    logic exp_err;
    do_reset();
    cur_res = '0; cur_ill = 1'b0;
    exp_ack = '0; exp_done = '0; exp_res = '0; exp_err = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Predict what the coming edge produces from the pending requests.
      exp_ack = '0;
      if (busy == 0) begin
        if (|req) begin
          cur      = pick(req);
          exp_ack  = NR'(1) << cur;
          cur_res  = alu_f(ta[cur], tbv[cur], top[cur]);
          cur_ill  = (top[cur] == 3'd7);
          rr_last  = cur;
          busy     = 2;
        end
      end else if (busy == 2) begin
        exp_done = NR'(1) << cur;
        exp_res  = cur_ill ? '0 : cur_res;
        exp_err  = cur_ill;
        busy     = 1;
      end else begin
        exp_done = '0;
        exp_err  = 1'b0;
        busy     = 0;
      end
      step();
      n_checks++;
      if (ack !== exp_ack || done !== exp_done || err !== exp_err || result !== exp_res) begin
        n_fail++;
        $display("FAIL random_cycle%0d: ack=%b done=%b err=%b result=%0d, expected %b %b %b %0d",
                 cyc, ack, done, err, result, exp_ack, exp_done, exp_err, exp_res);
      end
      // Requesters: drop or re-request after ack, occasionally raise a fresh request.
      for (int i = 0; i < NR; i++) begin
        if (exp_ack[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          ta[i]  = W'($urandom);
          tbv[i] = W'($urandom);
          top[i] = 3'($urandom_range(0, 7));
          req[i] = 1'b1;
        end
      end
    end
    req = '0;
    step();
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req = '0;
    ta = '0;
    tbv = '0;
    top = '0;
    step();
    test_reset();
    test_single();
    test_signed();
    test_illegal();
    test_arbitration();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 12, is the signed operand and result width in bits.
REQ-002 Parameter NUM_REQ, default 4, is the number of requesters sharing one ALU; legal range 2..8.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port req, input, NUM_REQ: per-requester operation request, level.
REQ-006 Port req_a, input, NUM_REQ*WIDTH: packed signed operand A; slice i belongs to requester i.
REQ-007 Port req_b, input, NUM_REQ*WIDTH: packed signed operand B; slice i belongs to requester i.
REQ-008 Port req_op, input, NUM_REQ*3: packed ALU opcode; slice i belongs to requester i.
REQ-009 Port ack, output, NUM_REQ: one-hot, one-cycle pulse; the request was accepted and its operands latched.
REQ-010 Port done, output, NUM_REQ: one-hot, one-cycle pulse; result is valid for that requester.
REQ-011 Port result, output, WIDTH: signed result, shared by all requesters; valid only while done is nonzero.
REQ-012 Port err, output, 1: asserted together with done when the opcode was illegal.
REQ-013 Port alu_a, output, WIDTH: registered operand A driven to the ALU.
REQ-014 Port alu_b, output, WIDTH: registered operand B driven to the ALU.
REQ-015 Port alu_op, output, 3: registered opcode driven to the ALU as selectOp.
REQ-016 Port alu_c, input, WIDTH: combinational ALU result.

Function
REQ-017 The FSM SHALL have three states: IDLE, EXEC and DONE.
REQ-018 In IDLE with any req bit high, at the edge the FSM SHALL:
- select a winner w;
- latch w's a, b and op into alu_a, alu_b and alu_op;
- assert ack[w] for the next cycle;
- move to EXEC.
REQ-019 In IDLE with req all zero, the block SHALL stay in IDLE with all outputs held.
REQ-020 In EXEC, at the edge the block SHALL register alu_c into result, assert done[w] for the next cycle and move to DONE.
REQ-021 In DONE, at the edge the block SHALL clear done and err and return to IDLE; no grant is issued in DONE.
REQ-022 Timing SHALL be: req sampled at edge N gives ack in cycle N+1 and done in cycle N+2; throughput is one operation per 3 cycles.
REQ-023 A requester SHALL hold req, a, b and op stable until it sees ack.
REQ-024 A req still high in the cycle after ack is a new request.
REQ-025 Opcode 7 SHALL be treated as illegal: ack and done are issued normally, result is forced to 0 and err is 1 during done.
REQ-026 Requests arriving while in EXEC or DONE SHALL wait; none is lost, because req is a level.
REQ-027 alu_a, alu_b and alu_op SHALL hold their values outside IDLE-to-EXEC transitions.
REQ-028 The result SHALL be WIDTH bits, exactly alu_c, with no extension or saturation.

Reset
REQ-029 When rst is high at an edge, including mid-operation, the block SHALL:
- go to IDLE;
- set ack, done, err, result, alu_a, alu_b and alu_op to 0;
- set the round-robin pointer to NUM_REQ-1, so requester 0 has highest priority first;
- drop any in-flight operation without issuing done.

Configuration
REQ-030 With macro ALU_ARB_ROUND_ROBIN_EN defined, the winner SHALL be the first requesting index strictly after the last winner, searching modulo NUM_REQ; the pointer updates only on a grant.
REQ-031 Without ALU_ARB_ROUND_ROBIN_EN, the winner SHALL be the lowest-index requesting bit (fixed priority) and no pointer register exists.

Verification
REQ-032 The bench ALU model SHALL return c=a+b for op 0 and c=a-b for op 1.
REQ-033 Single request: req[0] with a=10, b=3, op=0 at edge N -> ack[0] in cycle N+1; done[0] and result=13 in cycle N+2; back in IDLE at N+3.
REQ-034 Simultaneous requests with round-robin defined: req=4'b1111 held, each requester dropping its bit after its ack -> ack order 0,1,2,3, ack pulses exactly 3 cycles apart.
REQ-035 Simultaneous requests with round-robin undefined: req[1] and req[3] held continuously -> requester 1 is served repeatedly and requester 3 is never acked.
REQ-036 Signed operands: req[2] with a=20, b=-30, op=1 -> done[2] with result=50; err=0.
REQ-037 Illegal opcode: req[0] with op=7 -> ack[0], then done[0] with result=0 and err=1.
REQ-038 Reset mid-operation: rst asserted for one edge while in EXEC -> no done pulse and all outputs 0; a following req[3] is granted within 1 cycle.
